bk_sector_ctrl: RTL and testbench

//  Multi-slot save-state / backup-RAM sector sequencer between a core's nvram dpram and the hps_io SD sector interface.

---
 rtl/bk_pkg.sv | 6 +
 rtl/bk_tmo.sv | 27 ++
 rtl/bk_sector_ctrl.sv | 138 +++++++++++++
 tb/tb_bk_sector_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared types for the backup-RAM sector sequencer.
package bk_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} st_e;
  typedef enum logic {DIR_LOAD, DIR_SAVE} dir_e;
  localparam int SECT_BYTES = 512;
endpackage

// File: rtl/bk_tmo.sv
// Ack timeout: holds at TMO_CYC-1 while loaded, counts down while enabled, flags on reaching zero.
module bk_tmo #(
  parameter int unsigned TMO_CYC = 2**24
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  generate
    if (TMO_CYC == 0) begin : g_off
      logic w_unused;
      assign w_unused = ^{i_clk, i_reset, i_load, i_en};
      assign o_expire = 1'b0;
    end else begin : g_on
      localparam int W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
      localparam logic [W-1:0] LOAD_V = W'(TMO_CYC - 1);
      logic [W-1:0] r_cnt;
      always_ff @(posedge i_clk) begin
        if (i_reset || i_load) r_cnt <= LOAD_V;
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
      end
      assign o_expire = i_en && (r_cnt == '0);
    end
  endgenerate
endmodule

// File: rtl/bk_sector_ctrl.sv
// Streams one save slot between nvram and the SD sector interface, one sector per ack handshake.
module bk_sector_ctrl
  import bk_pkg::*;
#(
  parameter int          SLOT_BITS = 2,
  parameter int          SECT_BITS = 6,
  parameter logic [31:0] BASE_LBA  = 32'd0,
  parameter int unsigned TMO_CYC   = 2**24
) (
  input  logic                 i_clk_sys,
  input  logic                 i_reset,
  input  logic                 i_bk_ena,
  input  logic                 i_load_req,
  input  logic                 i_save_req,
  input  logic [SLOT_BITS-1:0] i_slot,
  input  logic                 i_auto_en,
  input  logic                 i_auto_trig,
  input  logic                 i_dirty,
  input  logic                 i_sd_ack,
  output logic [31:0]          o_sd_lba,
  output logic                 o_sd_rd,
  output logic                 o_sd_wr,
  output logic [SECT_BITS-1:0] o_sect_idx,
  output logic                 o_busy,
  output logic                 o_loading,
  output logic                 o_dirty_flag,
  output logic                 o_done,
  output logic                 o_err
);
  st_e                  r_state;
  dir_e                 r_dir;
  logic [SLOT_BITS-1:0] r_slot;
  logic [SECT_BITS-1:0] r_sect;
  logic [31:0]          r_lba;
  logic r_sd_rd, r_sd_wr, r_busy, r_loading, r_dirty_flag, r_dirty_pend, r_done, r_err;
  logic r_load_q, r_save_q, r_auto_q, r_ack_q;
  logic w_load_edge, w_save_edge, w_auto_edge, w_ack_rise, w_ack_fall, w_tmo_exp;
  logic [SECT_BITS-1:0] w_sect_nxt;
  logic [31:0]          w_lba_start, w_lba_nxt;

  assign w_load_edge = i_load_req & ~r_load_q & i_bk_ena;
  assign w_save_edge = i_save_req & ~r_save_q & i_bk_ena;
  assign w_auto_edge = i_auto_trig & ~r_auto_q & i_bk_ena & i_auto_en & r_dirty_flag;
  assign w_ack_rise  = i_sd_ack & ~r_ack_q;
  assign w_ack_fall  = ~i_sd_ack & r_ack_q;
  assign w_sect_nxt  = r_sect + SECT_BITS'(1);
  assign w_lba_start = BASE_LBA + 32'({i_slot, {SECT_BITS{1'b0}}});
  assign w_lba_nxt   = BASE_LBA + 32'({r_slot, w_sect_nxt});

  bk_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .i_clk    (i_clk_sys),
    .i_reset  (i_reset),
    .i_load   (r_state != ST_REQ),
    .i_en     (r_state == ST_REQ),
    .o_expire (w_tmo_exp)
  );

  always_ff @(posedge i_clk_sys) begin
    // Edge history tracks inputs even in reset so no edge fires on release.
    r_load_q <= i_load_req;
    r_save_q <= i_save_req;
    r_auto_q <= i_auto_trig;
    r_ack_q  <= i_sd_ack;
    r_done   <= 1'b0;
    r_err    <= 1'b0;
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_dir        <= DIR_LOAD;
      r_slot       <= '0;
      r_sect       <= '0;
      r_lba        <= '0;
      r_sd_rd      <= 1'b0;
      r_sd_wr      <= 1'b0;
      r_busy       <= 1'b0;
      r_loading    <= 1'b0;
      r_dirty_flag <= 1'b0;
      r_dirty_pend <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_load_edge || w_save_edge || w_auto_edge) begin
          r_dir        <= w_load_edge ? DIR_LOAD : DIR_SAVE;
          r_slot       <= i_slot;
          r_sect       <= '0;
          r_lba        <= w_lba_start;
          r_sd_rd      <= w_load_edge;
          r_sd_wr      <= ~w_load_edge;
          r_busy       <= 1'b1;
          r_loading    <= w_load_edge;
          r_dirty_pend <= 1'b0;
          r_state      <= ST_REQ;
        end
        ST_REQ: if (w_ack_rise) begin
          r_sd_rd <= 1'b0;
          r_sd_wr <= 1'b0;
          r_state <= ST_XFER;
        end else if (w_tmo_exp) begin
          r_sd_rd   <= 1'b0;
          r_sd_wr   <= 1'b0;
          r_busy    <= 1'b0;
          r_loading <= 1'b0;
          r_err     <= 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_XFER: if (w_ack_fall) begin
          if (&r_sect) begin
            r_busy       <= 1'b0;
            r_loading    <= 1'b0;
            r_done       <= 1'b1;
            // Writes made after the save started were not captured in the image.
            r_dirty_flag <= r_dirty_pend;
            r_state      <= ST_IDLE;
          end else begin
            r_sect  <= w_sect_nxt;
            r_lba   <= w_lba_nxt;
            r_sd_rd <= (r_dir == DIR_LOAD);
            r_sd_wr <= (r_dir == DIR_SAVE);
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (i_dirty && !r_loading) begin
        r_dirty_flag <= 1'b1;
        if (r_busy) r_dirty_pend <= 1'b1;
      end
    end
  end

  assign o_sd_lba     = r_lba;
  assign o_sd_rd      = r_sd_rd;
  assign o_sd_wr      = r_sd_wr;
  assign o_sect_idx   = r_sect;
  assign o_busy       = r_busy;
  assign o_loading    = r_loading;
  assign o_dirty_flag = r_dirty_flag;
  assign o_done       = r_done;
  assign o_err        = r_err;
endmodule

// File: tb/tb_bk_sector_ctrl.sv
// Scoreboard bench: expected sector requests and done/err events are queued by stimulus, popped by a monitor.
module tb_bk_sector_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bk_ena = 1'b1, load_req = 1'b0, save_req = 1'b0, auto_en = 1'b0;
  logic        auto_trig = 1'b0, dirty = 1'b0, sd_ack = 1'b0;
  logic [1:0]  slot = 2'd0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, busy, loading, dirty_flag, done, err;
  logic [5:0]  sect_idx;

  int checks = 0, failures = 0;
  bit ack_en = 1'b1;
  bit m_dirty = 1'b0;

  typedef struct {
    int          kind;   // 0 sector request, 1 done, 2 err
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    int          sect;
    logic        ld;
    logic        dty;
  } exp_t;
  exp_t q[$];
  exp_t me;

  bk_sector_ctrl #(.SLOT_BITS(2), .SECT_BITS(6), .BASE_LBA(32'd0), .TMO_CYC(100)) dut (
    .i_clk_sys(clk), .i_reset(rst), .i_bk_ena(bk_ena), .i_load_req(load_req),
    .i_save_req(save_req), .i_slot(slot), .i_auto_en(auto_en), .i_auto_trig(auto_trig),
    .i_dirty(dirty), .i_sd_ack(sd_ack), .o_sd_lba(sd_lba), .o_sd_rd(sd_rd), .o_sd_wr(sd_wr),
    .o_sect_idx(sect_idx), .o_busy(busy), .o_loading(loading), .o_dirty_flag(dirty_flag),
    .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic push_xfer(input bit is_load, input int sl, input bit dty_after);
    exp_t e;
    for (int s = 0; s < 64; s++) begin
      e.kind = 0; e.rd = is_load; e.wr = !is_load; e.lba = 32'(sl * 64 + s);
      e.sect = s; e.ld = is_load; e.dty = 1'b0;
      q.push_back(e);
    end
    e.kind = 1; e.dty = dty_after;
    q.push_back(e);
  endtask

  task automatic pulse_req(input bit ld, input bit sv, input bit au, input int sl);
    @(posedge clk); #1;
    slot = 2'(sl); load_req = ld; save_req = sv; auto_trig = au;
    @(posedge clk); #1;
    load_req = 1'b0; save_req = 1'b0; auto_trig = 1'b0;
  endtask

  task automatic pulse_dirty();
    @(posedge clk); #1 dirty = 1'b1;
    @(posedge clk); #1 dirty = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk(nm, busy, 0);
  endtask

  // hps_io stand-in: ack 0..4 cycles after a request, held 1..20 cycles
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ack_en && !rst && (sd_rd || sd_wr) && !sd_ack) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1 sd_ack = 1'b1;
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1 sd_ack = 1'b0;
      end
    end
  end

  logic p_rd = 1'b0, p_wr = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if ((sd_rd && !p_rd) || (sd_wr && !p_wr)) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req act=lba%0d exp=none", sd_lba);
        end else begin
          me = q.pop_front();
          chk("req_kind", 0, me.kind);
          chk("req_rd", sd_rd, me.rd);
          chk("req_wr", sd_wr, me.wr);
          chk("req_lba", sd_lba, me.lba);
          chk("req_sect", 32'(sect_idx), me.sect);
          chk("req_loading", loading, me.ld);
          chk("req_busy", busy, 1);
        end
      end
      if (done || err) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_end act=done%0d_err%0d exp=none", done, err);
        end else begin
          me = q.pop_front();
          chk("end_kind", done ? 1 : 2, me.kind);
          chk("end_busy", busy, 0);
          chk("end_loading", loading, 0);
          chk("end_rdwr", sd_rd | sd_wr, 0);
          chk("end_dirty_flag", dirty_flag, me.dty);
        end
      end
    end
    p_rd = sd_rd;
    p_wr = sd_wr;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_loading"}, loading, 0);
    chk({tag, "_rd"}, sd_rd, 0);
    chk({tag, "_wr"}, sd_wr, 0);
    chk({tag, "_lba"}, sd_lba, 0);
    chk({tag, "_sect"}, 32'(sect_idx), 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_dirty"}, dirty_flag, 0);
  endtask

  initial begin
    int n;
    exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // load slot 2; dirty while loading and a save edge mid-transfer are both ignored
    pulse_dirty();
    @(negedge clk); chk("dirty_set", dirty_flag, 1);
    push_xfer(1, 2, 0);
    pulse_req(1, 0, 0, 2);
    repeat (100) @(posedge clk);
    pulse_dirty();
    pulse_req(0, 1, 0, 0);
    wait_idle("load2_idle");
    m_dirty = 1'b0;

    // save slot 0 with a write landing mid-transfer
    pulse_dirty();
    push_xfer(0, 0, 1);
    pulse_req(0, 1, 0, 0);
    repeat (100) @(posedge clk);
    pulse_dirty();
    wait_idle("save0_idle");
    m_dirty = 1'b1;
    @(negedge clk); chk("save0_dirty_after", dirty_flag, m_dirty);

    // autosave fires only when dirty
    auto_en = 1'b1;
    push_xfer(0, 3, 0);
    pulse_req(0, 0, 1, 3);
    wait_idle("auto_idle");
    m_dirty = 1'b0;
    pulse_req(0, 0, 1, 3);
    repeat (10) @(posedge clk);
    @(negedge clk); chk("auto_clean_busy", busy, 0);

    // no start without a writable image
    bk_ena = 1'b0;
    pulse_req(1, 0, 0, 1);
    repeat (10) @(posedge clk);
    @(negedge clk); chk("no_ena_busy", busy, 0);
    bk_ena = 1'b1;

    // simultaneous load and save: load wins
    push_xfer(1, 1, 0);
    pulse_req(1, 1, 0, 1);
    wait_idle("both_idle");

    // ack never arrives: abort after 100 request cycles, dirty_flag untouched
    ack_en = 1'b0;
    pulse_dirty();
    m_dirty = 1'b1;
    e.kind = 0; e.rd = 1'b0; e.wr = 1'b1; e.lba = 32'd64; e.sect = 0; e.ld = 1'b0; e.dty = 1'b0;
    q.push_back(e);
    e.kind = 2; e.dty = m_dirty;
    q.push_back(e);
    pulse_req(0, 1, 0, 1);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (!sd_wr) break;
      n++;
    end
    chk("tmo_wr_cycles", n, 100);
    @(negedge clk); chk("tmo_busy", busy, 0);
    chk("tmo_dirty", dirty_flag, m_dirty);
    ack_en = 1'b1;

    // reset in the middle of sector 17, then a fresh load from sector 0
    push_xfer(1, 3, 0);
    pulse_req(1, 0, 0, 3);
    n = 0;
    do begin @(negedge clk); n++; end while (!(sect_idx == 6'd17 && sd_rd) && n < 3000);
    chk("reach_sect17", 32'(sect_idx), 17);
    @(posedge clk); #1 rst = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1 rst = 1'b0;
    m_dirty = 1'b0;
    repeat (40) @(posedge clk);
    push_xfer(1, 0, 0);
    pulse_req(1, 0, 0, 0);
    wait_idle("restart_idle");

    // random mix of loads and saves with optional writes during the transfer
    for (int i = 0; i < 4; i++) begin
      bit ld, mid;
      int sl;
      ld = 1'($urandom_range(0, 1));
      mid = 1'($urandom_range(0, 1));
      sl = int'($urandom_range(0, 3));
      push_xfer(ld, sl, ld ? 1'b0 : mid);
      pulse_req(ld, !ld, 0, sl);
      if (mid) begin
        repeat (100) @(posedge clk);
        pulse_dirty();
      end
      wait_idle("rand_idle");
      m_dirty = ld ? 1'b0 : mid;
      @(negedge clk); chk("rand_dirty", dirty_flag, m_dirty);
    end

    repeat (30) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
